// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions for the serial link generator and checker.
// Keeping lfsr_next here means both ends always use the same polynomial.
package lfsr_pkg;

  localparam int LFSR_WIDTH = 8;
  localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 8'b10101010;

  localparam int BIT_CNT_W = $clog2(LFSR_WIDTH + 1);

  typedef logic [LFSR_WIDTH-1:0] lfsr_word_t;
  typedef logic [BIT_CNT_W-1:0]  bit_cnt_t;

  localparam bit_cnt_t BIT_CNT_FULL = bit_cnt_t'(LFSR_WIDTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  // The all-zero term in the feedback lets the sequence leave (and pass through) 8'h00.
  function automatic lfsr_word_t lfsr_next(input lfsr_word_t l);
    logic       fb;
    lfsr_word_t n;
    fb   = l[LFSR_WIDTH-1] ^ ~|l[LFSR_WIDTH-2:0];
    n    = '0;
    n[0] = fb;
    for (int i = 1; i < LFSR_WIDTH; i++)
      n[i] = LFSR_TAPS[i] ? (fb ^ l[i-1]) : l[i-1];
    return n;
  endfunction

endpackage

// File: rtl/lfsr_serial_checker_if.sv
// Control and result signals of the LFSR serial link checker.
interface lfsr_serial_checker_if;
  import lfsr_pkg::*;

  lfsr_word_t Seed;
  logic [7:0] steps;
  logic       start;
  logic       serial_in;
  logic       serial_valid;
  lfsr_word_t rx_data;
  lfsr_word_t expected;
  logic       done;
  logic       match;
  logic       busy;
  logic [7:0] err_count;

  modport master (
    output Seed, steps, start, serial_in, serial_valid,
    input  rx_data, expected, done, match, busy, err_count
  );

  modport slave (
    input  Seed, steps, start, serial_in, serial_valid,
    output rx_data, expected, done, match, busy, err_count
  );

endinterface

// File: rtl/lfsr_serial_checker_deserializer.sv
// LSB-first deserialiser: the first accepted bit ends up in sreg[0].
// Stops capturing once WIDTH bits are in; extra bits are dropped.
module serial_deserializer
  import lfsr_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       serial_in,
  input  logic       serial_valid,
  output lfsr_word_t sreg,
  output logic       full
);

  bit_cnt_t bit_cnt;

  assign full = (bit_cnt == BIT_CNT_FULL);

  always_ff @(posedge clock) begin
    if (!reset) begin
      sreg    <= '0;
      bit_cnt <= '0;
    end else if (clear) begin
      bit_cnt <= '0;
    end else if (enable && serial_valid && !full) begin
      sreg    <= {serial_in, sreg[LFSR_WIDTH-1:1]};
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/lfsr_serial_checker.sv
// Receive end of the serial LFSR link: rebuilds the byte, regenerates it locally, compares.
//
// state | meaning
// IDLE  | waiting for start; serial bits ignored
// RUN   | advancing local LFSR and capturing serial bits concurrently
// CHECK | one cycle: publish rx_data/expected/match, count mismatches
module lfsr_serial_checker
  import lfsr_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  lfsr_serial_checker_if.slave bus
);

  logic [1:0] state;
  lfsr_word_t lfsr;
  logic [7:0] step_cnt;
  lfsr_word_t sreg;
  logic       full;
  logic       accept;

  lfsr_word_t rx_data_q;
  lfsr_word_t expected_q;
  logic       done_q;
  logic       match_q;
  logic [7:0] err_count_q;

  assign accept = (state == ST_IDLE) && bus.start;

  serial_deserializer u_deser (
    .clock        (clock),
    .reset        (reset),
    .clear        (accept),
    .enable       (state == ST_RUN),
    .serial_in    (bus.serial_in),
    .serial_valid (bus.serial_valid),
    .sreg         (sreg),
    .full         (full)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= ST_IDLE;
      lfsr        <= '0;
      step_cnt    <= '0;
      rx_data_q   <= '0;
      expected_q  <= '0;
      done_q      <= 1'b0;
      match_q     <= 1'b0;
      err_count_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            lfsr     <= bus.Seed;
            step_cnt <= bus.steps;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (step_cnt != 8'd0) begin
            lfsr     <= lfsr_next(lfsr);
            step_cnt <= step_cnt - 8'd1;
          end
          // Exit uses the registered counters, so the last step/bit costs one extra cycle.
          if (step_cnt == 8'd0 && full)
            state <= ST_CHECK;
        end
        ST_CHECK: begin
          rx_data_q  <= sreg;
          expected_q <= lfsr;
          match_q    <= (sreg == lfsr);
          done_q     <= 1'b1;
          if (sreg != lfsr && err_count_q != 8'hFF)
            err_count_q <= err_count_q + 8'd1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.expected  = expected_q;
  assign bus.done      = done_q;
  assign bus.match     = match_q;
  assign bus.busy      = (state == ST_RUN) || (state == ST_CHECK);
  assign bus.err_count = err_count_q;

endmodule
